// File: rtl/thread_ctx_pkg.sv
// Shared types and defaults for the per-thread architectural state unit.
// Imported by thread_ctx and thread_ctx_slot.
package thread_ctx_pkg;

  localparam int N_THREADS_DEF = 8;
  localparam int TID_W_DEF     = $clog2(N_THREADS_DEF);

  typedef logic [31:0]          word_t;
  typedef logic [31:0]          vptr_t;
  typedef logic [TID_W_DEF-1:0] threadid_t;

  localparam vptr_t RESET_PC_DEF   = 32'h0000_1000;
  localparam vptr_t EXC_VECTOR_DEF = 32'h0000_2000;

  typedef enum logic {
    USER       = 1'b0,
    SUPERVISOR = 1'b1
  } mode_e;

  // Jump and branch targets are word aligned; the two low bits are dropped.
  function automatic vptr_t align_word(input vptr_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/thread_ctx_slot.sv
// State of a single hardware thread: PC, rm0/rm1/rm2, mode (rm4[0]) and stall flag.
// Event selects arrive already decoded for this thread.
module thread_ctx_slot
  import thread_ctx_pkg::*;
#(
  parameter vptr_t RESET_PC   = RESET_PC_DEF,
  parameter vptr_t EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int    RESET_MODE = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_fetch,
  input  logic  i_redir,
  input  vptr_t i_redir_pc,
  input  logic  i_exc,
  input  vptr_t i_exc_pc,
  input  word_t i_exc_addr,
  input  word_t i_exc_cause,
  input  logic  i_iret,
  input  logic  i_stall_set,
  input  logic  i_stall_clr,
  output vptr_t o_pc,
  output logic  o_mode,
  output logic  o_stalled,
  output word_t o_rm0,
  output word_t o_rm1,
  output word_t o_rm2
);

  localparam mode_e MODE_AT_RESET = (RESET_MODE != 0) ? SUPERVISOR : USER;

  vptr_t r_pc;
  word_t r_rm0;
  word_t r_rm1;
  word_t r_rm2;
  mode_e r_mode;
  logic  r_stalled;

  // NOTE: every state register uses <= so all slots sample pre-edge values
  // together; blocking assignments here would let one update leak into another.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_rm0     <= '0;
      r_rm1     <= '0;
      r_rm2     <= '0;
      r_mode    <= MODE_AT_RESET;
      r_stalled <= 1'b0;
    end else if (i_exc) begin
      r_pc      <= EXC_VECTOR;
      r_rm0     <= i_exc_pc;
      r_rm1     <= i_exc_addr;
      r_rm2     <= i_exc_cause;
      r_mode    <= SUPERVISOR;
      r_stalled <= 1'b0;
    end else begin
      if (i_iret) begin
        r_pc   <= r_rm0;
        r_mode <= USER;
      end else if (i_redir) begin
        r_pc <= align_word(i_redir_pc);
      end else if (i_fetch && !r_stalled) begin
        r_pc <= r_pc + 32'd4;
      end

      // A new miss arriving with the fill of the previous one keeps the thread parked.
      if (i_stall_set) begin
        r_stalled <= 1'b1;
      end else if (i_stall_clr) begin
        r_stalled <= 1'b0;
      end
    end
  end

  assign o_pc      = r_pc;
  assign o_mode    = r_mode;
  assign o_stalled = r_stalled;
  assign o_rm0     = r_rm0;
  assign o_rm1     = r_rm1;
  assign o_rm2     = r_rm2;

endmodule

// File: rtl/thread_ctx.sv
// Per-thread architectural state for the multithreaded pipeline: decodes the
// fetch/writeback event thread ids to one-hot selects and fans them out to one slot per thread.
module thread_ctx
  import thread_ctx_pkg::*;
#(
  parameter int    N_THREADS  = N_THREADS_DEF,
  parameter int    TID_W      = $clog2(N_THREADS),
  parameter vptr_t RESET_PC   = RESET_PC_DEF,
  parameter vptr_t EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int    RESET_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_en,
  input  logic [TID_W-1:0]        fetch_thread,
  input  logic                    redir_en,
  input  logic [TID_W-1:0]        redir_thread,
  input  logic [31:0]             redir_pc,
  input  logic                    exc_en,
  input  logic [TID_W-1:0]        exc_thread,
  input  logic [31:0]             exc_pc,
  input  logic [31:0]             exc_addr,
  input  logic [31:0]             exc_cause,
  input  logic                    iret_en,
  input  logic [TID_W-1:0]        iret_thread,
  input  logic [N_THREADS-1:0]    stall_set,
  input  logic [N_THREADS-1:0]    stall_clr,
  output logic [N_THREADS*32-1:0] pc,
  output logic [N_THREADS-1:0]    mode,
  output logic [N_THREADS-1:0]    stalled,
  output logic [N_THREADS*32-1:0] rm0_q,
  output logic [N_THREADS*32-1:0] rm1_q,
  output logic [N_THREADS*32-1:0] rm2_q
);

  logic [N_THREADS-1:0] w_fetch_sel;
  logic [N_THREADS-1:0] w_redir_sel;
  logic [N_THREADS-1:0] w_exc_sel;
  logic [N_THREADS-1:0] w_iret_sel;

  // The enable rides in bit 0 before the shift, so a low enable yields no select at all.
  assign w_fetch_sel = {{(N_THREADS-1){1'b0}}, fetch_en} << fetch_thread;
  assign w_redir_sel = {{(N_THREADS-1){1'b0}}, redir_en} << redir_thread;
  assign w_exc_sel   = {{(N_THREADS-1){1'b0}}, exc_en}   << exc_thread;
  assign w_iret_sel  = {{(N_THREADS-1){1'b0}}, iret_en}  << iret_thread;

  for (genvar g = 0; g < N_THREADS; g++) begin : g_slot
    thread_ctx_slot #(
      .RESET_PC   (RESET_PC),
      .EXC_VECTOR (EXC_VECTOR),
      .RESET_MODE (RESET_MODE)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .i_fetch     (w_fetch_sel[g]),
      .i_redir     (w_redir_sel[g]),
      .i_redir_pc  (redir_pc),
      .i_exc       (w_exc_sel[g]),
      .i_exc_pc    (exc_pc),
      .i_exc_addr  (exc_addr),
      .i_exc_cause (exc_cause),
      .i_iret      (w_iret_sel[g]),
      .i_stall_set (stall_set[g]),
      .i_stall_clr (stall_clr[g]),
      .o_pc        (pc[32*g +: 32]),
      .o_mode      (mode[g]),
      .o_stalled   (stalled[g]),
      .o_rm0       (rm0_q[32*g +: 32]),
      .o_rm1       (rm1_q[32*g +: 32]),
      .o_rm2       (rm2_q[32*g +: 32])
    );
  end

endmodule

// File: tb/tb_thread_ctx.sv
// Self-checking bench for thread_ctx: directed scenarios plus randomized traffic
// compared against a per-thread reference model built from the event rules.
module tb_thread_ctx;

  localparam int NT = 8;
  localparam int TW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           fetch_en;
  logic [TW-1:0]  fetch_thread;
  logic           redir_en;
  logic [TW-1:0]  redir_thread;
  logic [31:0]    redir_pc;
  logic           exc_en;
  logic [TW-1:0]  exc_thread;
  logic [31:0]    exc_pc;
  logic [31:0]    exc_addr;
  logic [31:0]    exc_cause;
  logic           iret_en;
  logic [TW-1:0]  iret_thread;
  logic [NT-1:0]  stall_set;
  logic [NT-1:0]  stall_clr;
  logic [NT*32-1:0] pc;
  logic [NT-1:0]  mode;
  logic [NT-1:0]  stalled;
  logic [NT*32-1:0] rm0_q;
  logic [NT*32-1:0] rm1_q;
  logic [NT*32-1:0] rm2_q;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_pc   [NT];
  logic [31:0] m_rm0  [NT];
  logic [31:0] m_rm1  [NT];
  logic [31:0] m_rm2  [NT];
  logic        m_mode [NT];
  logic        m_stall[NT];

  thread_ctx #(
    .N_THREADS  (NT),
    .TID_W      (TW),
    .RESET_PC   (32'h0000_1000),
    .EXC_VECTOR (32'h0000_2000),
    .RESET_MODE (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .fetch_thread (fetch_thread),
    .redir_en     (redir_en),
    .redir_thread (redir_thread),
    .redir_pc     (redir_pc),
    .exc_en       (exc_en),
    .exc_thread   (exc_thread),
    .exc_pc       (exc_pc),
    .exc_addr     (exc_addr),
    .exc_cause    (exc_cause),
    .iret_en      (iret_en),
    .iret_thread  (iret_thread),
    .stall_set    (stall_set),
    .stall_clr    (stall_clr),
    .pc           (pc),
    .mode         (mode),
    .stalled      (stalled),
    .rm0_q        (rm0_q),
    .rm1_q        (rm1_q),
    .rm2_q        (rm2_q)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst          = 1'b0;
    fetch_en     = 1'b0;
    fetch_thread = '0;
    redir_en     = 1'b0;
    redir_thread = '0;
    redir_pc     = '0;
    exc_en       = 1'b0;
    exc_thread   = '0;
    exc_pc       = '0;
    exc_addr     = '0;
    exc_cause    = '0;
    iret_en      = 1'b0;
    iret_thread  = '0;
    stall_set    = '0;
    stall_clr    = '0;
  endtask

  // Next state of each thread: start from the lowest-priority effect and let
  // each higher-priority event overwrite what it owns.
  task automatic model_update();
    logic [31:0] npc;
    logic        nmode;
    logic        nstall;
    for (int i = 0; i < NT; i++) begin
      if (rst) begin
        m_pc[i] = 32'h1000; m_rm0[i] = 0; m_rm1[i] = 0; m_rm2[i] = 0;
        m_mode[i] = 1'b1; m_stall[i] = 1'b0;
      end else begin
        npc    = m_pc[i];
        nmode  = m_mode[i];
        nstall = (m_stall[i] && !stall_clr[i]) || stall_set[i];
        if (fetch_en && fetch_thread == i && !m_stall[i]) npc = m_pc[i] + 32'd4;
        if (redir_en && redir_thread == i) npc = redir_pc - (redir_pc % 4);
        if (iret_en && iret_thread == i) begin
          npc = m_rm0[i]; nmode = 1'b0;
        end
        if (exc_en && exc_thread == i) begin
          npc = 32'h2000; nmode = 1'b1; nstall = 1'b0;
          m_rm0[i] = exc_pc; m_rm1[i] = exc_addr; m_rm2[i] = exc_cause;
        end
        m_pc[i] = npc; m_mode[i] = nmode; m_stall[i] = nstall;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    for (int i = 0; i < NT; i++) begin
      n_vec++;
      if (pc[32*i +: 32] !== 32'h1000) begin
        n_err++; $display("FAIL reset_pc[%0d] got %h want %h", i, pc[32*i +: 32], 32'h1000);
      end
      n_vec++;
      if (rm0_q[32*i +: 32] !== 0 || rm1_q[32*i +: 32] !== 0 || rm2_q[32*i +: 32] !== 0) begin
        n_err++; $display("FAIL reset_rm[%0d] got %h/%h/%h want 0", i,
                          rm0_q[32*i +: 32], rm1_q[32*i +: 32], rm2_q[32*i +: 32]);
      end
    end
    n_vec++;
    if (mode !== 8'hFF) begin n_err++; $display("FAIL reset_mode got %h want ff", mode); end
    n_vec++;
    if (stalled !== 8'h00) begin n_err++; $display("FAIL reset_stalled got %h want 00", stalled); end
  endtask

  task automatic test_fetch();
    for (int k = 0; k < 3; k++) begin
      fetch_en = 1'b1; fetch_thread = 3'd3;
      step();
    end
    n_vec++;
    if (pc[96 +: 32] !== 32'h100C) begin n_err++; $display("FAIL fetch_pc3 got %h want 100c", pc[96 +: 32]); end
    for (int i = 0; i < NT; i++) begin
      if (i != 3) begin
        n_vec++;
        if (pc[32*i +: 32] !== 32'h1000) begin
          n_err++; $display("FAIL fetch_other_pc[%0d] got %h want 1000", i, pc[32*i +: 32]);
        end
      end
    end
    redir_en = 1'b1; redir_thread = 3'd3; redir_pc = 32'hFFFF_FFFC;
    step();
    fetch_en = 1'b1; fetch_thread = 3'd3;
    step();
    n_vec++;
    if (pc[96 +: 32] !== 32'h0) begin n_err++; $display("FAIL fetch_wrap got %h want 0", pc[96 +: 32]); end
  endtask

  task automatic test_stall();
    stall_set[2] = 1'b1;
    step();
    fetch_en = 1'b1; fetch_thread = 3'd2;
    step();
    n_vec++;
    if (pc[64 +: 32] !== 32'h1000) begin n_err++; $display("FAIL stall_fetch_pc2 got %h want 1000", pc[64 +: 32]); end
    stall_set[2] = 1'b1; stall_clr[2] = 1'b1;
    step();
    n_vec++;
    if (stalled[2] !== 1'b1) begin n_err++; $display("FAIL stall_set_wins got %b want 1", stalled[2]); end
    stall_clr[2] = 1'b1;
    step();
    n_vec++;
    if (stalled[2] !== 1'b0) begin n_err++; $display("FAIL stall_clr got %b want 0", stalled[2]); end
    fetch_en = 1'b1; fetch_thread = 3'd2;
    step();
    n_vec++;
    if (pc[64 +: 32] !== 32'h1004) begin n_err++; $display("FAIL stall_resume_pc2 got %h want 1004", pc[64 +: 32]); end
  endtask

  task automatic test_priority();
    redir_en = 1'b1; redir_thread = 3'd5; redir_pc = 32'h3003;
    fetch_en = 1'b1; fetch_thread = 3'd5;
    step();
    n_vec++;
    if (pc[160 +: 32] !== 32'h3000) begin n_err++; $display("FAIL redir_over_fetch got %h want 3000", pc[160 +: 32]); end
    exc_en = 1'b1; exc_thread = 3'd1; exc_pc = 32'h1000; exc_addr = 32'h44; exc_cause = 32'd7;
    redir_en = 1'b1; redir_thread = 3'd1; redir_pc = 32'h5000;
    step();
    n_vec++;
    if (pc[32 +: 32] !== 32'h2000) begin n_err++; $display("FAIL exc_over_redir got %h want 2000", pc[32 +: 32]); end
  endtask

  task automatic test_exc_iret();
    exc_en = 1'b1; exc_thread = 3'd4; exc_pc = 32'h1040; exc_addr = 32'hDEAD_0000; exc_cause = 32'd2;
    stall_set[4] = 1'b1;
    step();
    n_vec++;
    if (rm0_q[128 +: 32] !== 32'h1040) begin n_err++; $display("FAIL exc_rm0 got %h want 1040", rm0_q[128 +: 32]); end
    n_vec++;
    if (rm1_q[128 +: 32] !== 32'hDEAD_0000) begin n_err++; $display("FAIL exc_rm1 got %h want dead0000", rm1_q[128 +: 32]); end
    n_vec++;
    if (rm2_q[128 +: 32] !== 32'd2) begin n_err++; $display("FAIL exc_rm2 got %h want 2", rm2_q[128 +: 32]); end
    n_vec++;
    if (mode[4] !== 1'b1) begin n_err++; $display("FAIL exc_mode got %b want 1", mode[4]); end
    n_vec++;
    if (stalled[4] !== 1'b0) begin n_err++; $display("FAIL exc_clears_stall got %b want 0", stalled[4]); end
    n_vec++;
    if (pc[128 +: 32] !== 32'h2000) begin n_err++; $display("FAIL exc_pc got %h want 2000", pc[128 +: 32]); end
    iret_en = 1'b1; iret_thread = 3'd4;
    step();
    n_vec++;
    if (pc[128 +: 32] !== 32'h1040) begin n_err++; $display("FAIL iret_pc got %h want 1040", pc[128 +: 32]); end
    n_vec++;
    if (mode[4] !== 1'b0) begin n_err++; $display("FAIL iret_mode got %b want 0", mode[4]); end
    n_vec++;
    if (rm1_q[128 +: 32] !== 32'hDEAD_0000) begin n_err++; $display("FAIL iret_keeps_rm1 got %h want dead0000", rm1_q[128 +: 32]); end
  endtask

  task automatic test_rst_discard();
    rst = 1'b1;
    exc_en = 1'b1; exc_thread = 3'd0; exc_pc = 32'hABCD_0000; exc_addr = 32'h1; exc_cause = 32'h3;
    fetch_en = 1'b1; fetch_thread = 3'd0;
    step();
    n_vec++;
    if (pc[0 +: 32] !== 32'h1000) begin n_err++; $display("FAIL rst_discard_pc got %h want 1000", pc[0 +: 32]); end
    n_vec++;
    if (rm0_q[0 +: 32] !== 32'h0) begin n_err++; $display("FAIL rst_discard_rm0 got %h want 0", rm0_q[0 +: 32]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(63) == 0);
      fetch_en     = $urandom_range(1);
      fetch_thread = TW'($urandom_range(NT-1));
      redir_en     = ($urandom_range(3) == 0);
      redir_thread = TW'($urandom_range(NT-1));
      redir_pc     = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
      exc_en       = ($urandom_range(7) == 0);
      exc_thread   = TW'($urandom_range(NT-1));
      exc_pc       = $urandom;
      exc_addr     = $urandom;
      exc_cause    = $urandom;
      iret_en      = ($urandom_range(5) == 0);
      iret_thread  = TW'($urandom_range(NT-1));
      stall_set    = NT'($urandom) & NT'($urandom) & NT'($urandom);
      stall_clr    = NT'($urandom) & NT'($urandom);
      step();
      for (int i = 0; i < NT; i++) begin
        n_vec++;
        if (pc[32*i +: 32] !== m_pc[i] || mode[i] !== m_mode[i] || stalled[i] !== m_stall[i] ||
            rm0_q[32*i +: 32] !== m_rm0[i] || rm1_q[32*i +: 32] !== m_rm1[i] ||
            rm2_q[32*i +: 32] !== m_rm2[i]) begin
          n_err++;
          $display("FAIL random c%0d t%0d got pc=%h m=%b s=%b rm=%h/%h/%h want pc=%h m=%b s=%b rm=%h/%h/%h",
                   c, i, pc[32*i +: 32], mode[i], stalled[i],
                   rm0_q[32*i +: 32], rm1_q[32*i +: 32], rm2_q[32*i +: 32],
                   m_pc[i], m_mode[i], m_stall[i], m_rm0[i], m_rm1[i], m_rm2[i]);
        end
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_fetch();
    test_stall();
    test_priority();
    test_exc_iret();
    test_rst_discard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
